seq_magnitude_compare: RTL and testbench

Parametrised, multi-cycle magnitude comparator that succeeds the fixed 8-bit combinational "A greater than B" gate network in the ALU.

- Compares two WIDTH-bit operands DIGIT bits per cycle, most-significant digit first, with early termination on the first differing digit.
- Supports unsigned and two's-complement signed compare, and reports a full gt/eq/lt result.
- Sits between the ALU operand registers and the flag/branch logic, using a valid/ready handshake on both sides.

---
 rtl/seq_magnitude_compare_pkg.sv | 21 ++
 rtl/seq_magnitude_compare_compare_digit.sv | 18 +
 rtl/seq_magnitude_compare.sv | 127 ++++++++++++
 tb/tb_seq_magnitude_compare.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_compare_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t          : FSM encoding (IDLE, SCAN, DONE)
//   calc_num_digits  : number of DIGIT-wide scan steps for a WIDTH-bit operand
//   calc_cnt_width   : digit counter width, clog2(num_digits) with a minimum of 1
package seq_magnitude_compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cnt_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_compare_compare_digit.sv
// compare_digit: purely combinational unsigned compare of one DIGIT-wide digit.
//   i_a_dig   : digit of operand A
//   i_b_dig   : digit of operand B
//   o_dig_gt  : A digit > B digit
//   o_dig_eq  : A digit == B digit
module compare_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a_dig,
  input  logic [DIGIT-1:0] i_b_dig,
  output logic             o_dig_gt,
  output logic             o_dig_eq
);

  assign o_dig_gt = (i_a_dig > i_b_dig);
  assign o_dig_eq = (i_a_dig == i_b_dig);

endmodule

// File: rtl/seq_magnitude_compare.sv
// seq_magnitude_compare: multi-cycle gt/eq/lt comparator scanning DIGIT bits per
// cycle, most-significant digit first, stopping on the first differing digit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_valid/ready : request handshake carrying a, b, is_signed
//   a, b              : WIDTH-bit operands
//   is_signed         : 1 = two's-complement compare, 0 = unsigned
//   res_valid/ready   : result handshake
//   gt, eq, lt        : one-hot result while res_valid is high
//   o_dbg_state       : current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. start_ready is high only in IDLE and res_valid only in DONE; both are
// decoded from state alone, so neither depends combinationally on any input.
// start_valid is ignored outside IDLE.
module seq_magnitude_compare
  import seq_magnitude_compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [1:0]       o_dbg_state
);

  localparam int NUM_DIGITS = calc_num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = calc_cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_gt;
  logic               r_eq;
  logic               r_lt;

  logic               w_start_hs;
  logic               w_last;
  logic               w_dig_gt;
  logic               w_dig_eq;
  logic [WIDTH-1:0]   w_sign_flip;

  assign w_start_hs = start_valid & (r_state == ST_IDLE);
  assign w_last     = (r_cnt == LAST_CNT);

  // Inverting the MSB maps two's-complement onto offset-binary, so the scan
  // below only ever needs an unsigned digit compare.
  assign w_sign_flip = WIDTH'(is_signed) << (WIDTH - 1);

  compare_digit #(
    .DIGIT (DIGIT)
  ) u_compare_digit (
    .i_a_dig  (r_a[WIDTH-1 -: DIGIT]),
    .i_b_dig  (r_b[WIDTH-1 -: DIGIT]),
    .o_dig_gt (w_dig_gt),
    .o_dig_eq (w_dig_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start_valid)              w_next_state = ST_SCAN;
      ST_SCAN: if (!w_dig_eq || w_last)      w_next_state = ST_DONE;
      ST_DONE: if (res_ready)                w_next_state = ST_IDLE;
      default:                               w_next_state = ST_IDLE;
    endcase
  end

  // Operand shift registers, digit counter and result flags. Result flags are
  // only rewritten when a scan terminates, so they hold across IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_start_hs) begin
      r_a   <= a ^ w_sign_flip;
      r_b   <= b ^ w_sign_flip;
      r_cnt <= '0;
    end else if (r_state == ST_SCAN) begin
      if (!w_dig_eq) begin
        r_gt <= w_dig_gt;
        r_lt <= ~w_dig_gt;
        r_eq <= 1'b0;
      end else if (w_last) begin
        r_gt <= 1'b0;
        r_lt <= 1'b0;
        r_eq <= 1'b1;
      end else begin
        r_a   <= r_a << DIGIT;
        r_b   <= r_b << DIGIT;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign res_valid   = (r_state == ST_DONE);
  assign gt          = r_gt;
  assign eq          = r_eq;
  assign lt          = r_lt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Self-checking bench for seq_magnitude_compare (WIDTH=16, DIGIT=4).
module tb_seq_magnitude_compare;
  import seq_magnitude_compare_pkg::*;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int ND    = WIDTH / DIGIT;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_signed;
  logic             res_valid;
  logic             res_ready;
  logic             gt, eq, lt;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  seq_magnitude_compare #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (op_a),
    .b           (op_b),
    .is_signed   (is_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: {gt,eq,lt} from plain arithmetic
  function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
    if (s) begin
      if ($signed(a) > $signed(b))      return 3'b100;
      else if ($signed(a) < $signed(b)) return 3'b001;
      else                              return 3'b010;
    end else begin
      if (a > b)      return 3'b100;
      else if (a < b) return 3'b001;
      else            return 3'b010;
    end
  endfunction

  // reference latency: first differing digit position + 2, or ND + 1 when equal
  function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int p = 0; p < ND; p++) begin
      int sh;
      sh = WIDTH - DIGIT * (p + 1);
      if (((a >> sh) & ((1 << DIGIT) - 1)) != ((b >> sh) & ((1 << DIGIT) - 1)))
        return p + 2;
    end
    return ND + 1;
  endfunction

  // driver: called at a negedge; returns at the negedge where res_valid is first seen
  task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, input string tag);
    int lat;
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    is_signed   = s;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = 16'($urandom);
    op_b        = 16'($urandom);
    is_signed   = 1'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (res_valid || lat > 20) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_latency(a, b)));
    check({tag, "_result"}, 32'({gt, eq, lt}), 32'(ref_result(a, b, s)));
  endtask

  task automatic retire(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, m;
    logic             rs;
    int               k;

    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    is_signed   = 1'b0;
    #12;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_flags", 32'({gt, eq, lt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // equal operands and last-digit differences
    start_and_wait(16'h1234, 16'h1234, 1'b0, "equal");      retire("equal");
    start_and_wait(16'h1235, 16'h1234, 1'b0, "last_gt");    retire("last_gt");
    start_and_wait(16'h1234, 16'h1235, 1'b0, "last_lt");    retire("last_lt");

    // sign bit handling
    start_and_wait(16'h8000, 16'h7FFF, 1'b0, "uns_sign");   retire("uns_sign");
    start_and_wait(16'h8000, 16'h7FFF, 1'b1, "sgn_sign");   retire("sgn_sign");
    start_and_wait(16'hFFFF, 16'h0001, 1'b1, "sgn_neg1");   retire("sgn_neg1");

    // backpressure: result must hold and a request in DONE must be ignored
    start_and_wait(16'h00F0, 16'h0F00, 1'b0, "bp");
    start_valid = 1'b1;
    op_a        = 16'hFFFF;
    op_b        = 16'h0000;
    is_signed   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_flags", 32'({gt, eq, lt}), 32'b001);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    retire("bp");
    repeat (2) @(negedge clk);
    check("bp_not_captured_state", 32'(dbg_state), 32'(ST_IDLE));
    check("bp_not_captured_flags", 32'({gt, eq, lt}), 32'b001);

    // reset mid-SCAN
    start_valid = 1'b1;
    op_a        = 16'h1234;
    op_b        = 16'h1234;
    is_signed   = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_flags", 32'({gt, eq, lt}), 32'd0);
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    start_and_wait(16'h0001, 16'h0002, 1'b0, "post_rst");   retire("post_rst");

    // randomized sweep, biased to share a random number of leading digits
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      k  = $urandom_range(0, ND);
      m  = 16'hFFFF << (WIDTH - DIGIT * k);
      rb = (ra & m) | (rb & ~m);
      rs = 1'($urandom_range(0, 1));
      start_and_wait(ra, rb, rs, "rand");
      retire("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
